// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with two operand registers and an accumulator.
// Ops: 00 xor, 01 add, 10 subtract (1-cycle), 11 unsigned multiply
// (shift-add, WIDTH cycles, full-width product in {C_hi,C}).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   A, B       operand data, captured by load1 / load2
//   load1/2    operand register load enables (honoured in any state)
//   op_select  operation code
//   start      operation request, sampled only in IDLE
//   busy       high while a multiply is in progress
//   done       one-cycle pulse when C and the flags update
//   C, C_hi    result low / high half (C_hi is 0 for non-multiply ops)
//   carry, zero, negative, overflow  status flags
module seq_alu #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             load1,
  input  logic             load2,
  input  logic [1:0]       op_select,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  state_t             state, state_next;
  logic [WIDTH-1:0]   op1, op2;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [CNTW-1:0]    cnt;
  logic               last_iter;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;

  // Subtract reuses the adder as opA + ~opB + 1, so carry-out is "no borrow".
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    b_eff     = (op_select == OP_SUB) ? ~op2 : op2;
    sum       = {1'b0, op1} + {1'b0, b_eff} +
                {{WIDTH{1'b0}}, (op_select == OP_SUB)};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_select)
      OP_XOR: alu_res = op1 ^ op2;
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        // Signed overflow: same-sign inputs giving a different-sign result.
        alu_ovf   = (op1[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // One shift-add step; the counter value 1 marks the final iteration.
  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == CNTW'(1));
  assign busy      = (state == MUL);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && op_select == OP_MUL) state_next = MUL;
      MUL:  if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: all datapath registers are reset, including the multiplier
  // working registers, so a multiply aborted by reset leaves no residue.
  always_ff @(posedge clk) begin
    if (reset) begin
      op1      <= '0;
      op2      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
      C        <= '0;
      C_hi     <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load1) op1 <= A;
      if (load2) op2 <= B;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_select == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, op1};
              mplier <= op2;
              prod   <= '0;
              cnt    <= CNTW'(WIDTH);
            end else begin
              C        <= alu_res;
              C_hi     <= '0;
              carry    <= alu_carry;
              overflow <= alu_ovf;
              zero     <= (alu_res == '0);
              negative <= alu_res[WIDTH-1];
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          prod   <= prod_next;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt - CNTW'(1);
          if (last_iter) begin
            C        <= prod_next[WIDTH-1:0];
            C_hi     <= prod_next[2*WIDTH-1:WIDTH];
            carry    <= (prod_next[2*WIDTH-1:WIDTH] != '0);
            overflow <= 1'b0;
            zero     <= (prod_next[WIDTH-1:0] == '0);
            negative <= prod_next[WIDTH-1];
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: a WIDTH=4 instance and a WIDTH=8 instance.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       rst4 = 1'b1, l1_4 = 1'b0, l2_4 = 1'b0, st4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [1:0] op4 = '0;
  logic       busy4, done4, cy4, z4, n4, v4;
  logic [3:0] c4, chi4;

  seq_alu #(.WIDTH(4), .CNTW(5)) dut4 (
    .clk(clk), .reset(rst4), .A(a4), .B(b4), .load1(l1_4), .load2(l2_4),
    .op_select(op4), .start(st4), .busy(busy4), .done(done4), .C(c4),
    .C_hi(chi4), .carry(cy4), .zero(z4), .negative(n4), .overflow(v4)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic       rst8 = 1'b1, l1_8 = 1'b0, l2_8 = 1'b0, st8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] op8 = '0;
  logic       busy8, done8, cy8, z8, n8, v8;
  logic [7:0] c8, chi8;

  seq_alu #(.WIDTH(8), .CNTW(5)) dut8 (
    .clk(clk), .reset(rst8), .A(a8), .B(b8), .load1(l1_8), .load2(l2_8),
    .op_select(op8), .start(st8), .busy(busy8), .done(done8), .C(c8),
    .C_hi(chi8), .carry(cy8), .zero(z8), .negative(n8), .overflow(v8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b);
    a4 = a; b4 = b; l1_4 = 1'b1; l2_4 = 1'b1;
    tick();
    l1_4 = 1'b0; l2_4 = 1'b0;
  endtask

  // Single-cycle op; checks result, flags and the done pulse shape.
  task automatic alu4(input string tag, input logic [1:0] op,
                      input logic [3:0] exp_c, input logic exp_cy,
                      input logic exp_v);
    op4 = op; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    check({tag, "_done"}, done4, 1'b1);
    check({tag, "_c"}, c4, exp_c);
    check({tag, "_chi"}, chi4, 4'h0);
    check({tag, "_carry"}, cy4, exp_cy);
    check({tag, "_ovf"}, v4, exp_v);
    check({tag, "_zero"}, z4, exp_c == 4'h0);
    check({tag, "_neg"}, n4, exp_c[3]);
    tick();
    check({tag, "_done_low"}, done4, 1'b0);
  endtask

  // Multiply on the 4-bit instance: busy for 4 cycles, done on 4th edge.
  task automatic mul4(input string tag, input logic [7:0] exp_p);
    op4 = 2'b11; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    check({tag, "_busy0"}, busy4, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check({tag, "_busy_mid"}, {busy4, done4}, 2'b10);
    end
    tick();
    check({tag, "_done"}, {busy4, done4}, 2'b01);
    check({tag, "_c"}, c4, exp_p[3:0]);
    check({tag, "_chi"}, chi4, exp_p[7:4]);
    check({tag, "_carry"}, cy4, exp_p[7:4] != 4'h0);
    check({tag, "_ovf"}, v4, 1'b0);
    tick();
    check({tag, "_done_low"}, done4, 1'b0);
  endtask

  initial begin
    // Reset both instances and check the reset state.
    tick();
    rst4 = 1'b0; rst8 = 1'b0;
    check("rst_c", {chi4, c4}, 8'h00);
    check("rst_flags", {busy4, done4, cy4, z4, n4, v4}, 6'b0);

    // Test 1: A=5, B=2 through xor, add, subtract.
    load4(4'd5, 4'd2);
    alu4("xor52", 2'b00, 4'b0111, 1'b0, 1'b0);
    alu4("add52", 2'b01, 4'd7,    1'b0, 1'b0);
    alu4("sub52", 2'b10, 4'd3,    1'b1, 1'b0);

    // Test 2: borrow case and signed overflow on add.
    load4(4'd2, 4'd5);
    alu4("sub25", 2'b10, 4'b1101, 1'b0, 1'b0);
    load4(4'd7, 4'd1);
    alu4("add71", 2'b01, 4'b1000, 1'b0, 1'b1);

    // Test 3: multiplies.
    load4(4'd5, 4'd2);
    mul4("mul52", 8'd10);
    load4(4'd15, 4'd15);
    mul4("mulff", 8'd225);

    // Test 4: start and load1 during MUL; product uses old operands.
    load4(4'd5, 4'd2);
    op4 = 2'b11; st4 = 1'b1;
    tick();
    op4 = 2'b01; a4 = 4'd3; l1_4 = 1'b1;
    tick();
    st4 = 1'b0; l1_4 = 1'b0;
    check("ign_busy", busy4, 1'b1);
    tick(); tick();
    check("ign_busy3", {busy4, done4}, 2'b10);
    tick();
    check("ign_done", {busy4, done4}, 2'b01);
    check("ign_prod", {chi4, c4}, 8'd10);
    tick();
    alu4("add32", 2'b01, 4'd5, 1'b0, 1'b0);

    // Test 5: reset on the 2nd cycle of a multiply.
    load4(4'd7, 4'd3);
    op4 = 2'b11; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check("abort_out", {chi4, c4}, 8'h00);
    check("abort_flags", {busy4, done4, cy4, z4, n4, v4}, 6'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_nodone", {busy4, done4}, 2'b00);
    end
    alu4("add00", 2'b01, 4'd0, 1'b0, 1'b0);

    // Load and start in the same cycle: op uses the old operand (0).
    a4 = 4'd6; l1_4 = 1'b1;
    alu4("ldst_old", 2'b01, 4'd0, 1'b0, 1'b0);
    l1_4 = 1'b0;
    alu4("ldst_new", 2'b01, 4'd6, 1'b0, 1'b0);

    // Test 6: WIDTH=8 multiply 200*100 and add.
    a8 = 8'd200; b8 = 8'd100; l1_8 = 1'b1; l2_8 = 1'b1;
    tick();
    l1_8 = 1'b0; l2_8 = 1'b0;
    op8 = 2'b11; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("w8_busy_mid", {busy8, done8}, 2'b10);
    end
    tick();
    check("w8_done", {busy8, done8}, 2'b01);
    check("w8_prod", {chi8, c8}, 16'h4E20);
    check("w8_carry", cy8, 1'b1);
    tick();
    op8 = 2'b01; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    check("w8_add_done", done8, 1'b1);
    check("w8_add_c", c8, 8'd44);
    check("w8_add_chi", chi8, 8'd0);
    check("w8_add_carry", cy8, 1'b1);
    check("w8_add_ovf", v8, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
